// File: rtl/bf16_acc_issuer_if.sv
// Core-side request/response handshake bundle for the BF16 accelerator issuer.
// The core drives the master side; the issuer uses the slave side.
interface bf16_acc_issuer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [31:0]      req_c;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [31:0]      rsp_fpcsr;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_error;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_fpcsr, rsp_tag, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_fpcsr, rsp_tag, rsp_error
  );
endinterface

// File: rtl/bf16_acc_issuer.sv
// Request-side controller for bf16_accelerator_top: drives one operation for a
// fixed window, samples the outcome, returns a tagged response, keeps sticky flags.
module bf16_acc_issuer #(
  parameter int RESULT_LAT = 2,
  parameter int TAG_W      = 4
) (
  input  logic          clk,
  input  logic          reset,
  bf16_acc_issuer_if.slave core,
  output logic          acc_enable,
  output logic [31:0]   acc_operand_a,
  output logic [31:0]   acc_operand_b,
  output logic [31:0]   acc_operand_c,
  output logic [3:0]    acc_operation,
  input  logic [31:0]   acc_result,
  input  logic [31:0]   acc_fpcsr,
  input  logic          acc_valid,
  output logic [4:0]    fflags,
  input  logic          fflags_clr,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       cnt_r;
  logic             acc_enable_r;
  logic [31:0]      op_a_r;
  logic [31:0]      op_b_r;
  logic [31:0]      op_c_r;
  logic [3:0]       operation_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_result_r;
  logic [31:0]      rsp_fpcsr_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             rsp_error_r;
  logic [4:0]       fflags_r;
  logic             legal_op_s;
  logic             accept_s;
  logic             sample_s;
  logic             rsp_done_s;
  logic             req_ready_s;
  logic             busy_s;
  logic             flag_update_s;

  assign legal_op_s = (core.req_op <= 4'b1010);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (core.req_valid) begin
          state_nxt_s = legal_op_s ? ISSUE : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      RESP: begin
        if (core.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-decoded strobes and the two combinational outputs
  always_comb begin
    req_ready_s = (state_r == IDLE);
    busy_s      = (state_r != IDLE);
    accept_s    = (state_r == IDLE) && core.req_valid;
    sample_s    = (state_r == ISSUE) && (cnt_r == 4'd0);
    rsp_done_s  = (state_r == RESP) && core.rsp_ready;
  end

  // Issue window and response capture; operands keep their last value outside ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r        <= 4'd0;
      acc_enable_r <= 1'b0;
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      op_c_r       <= 32'd0;
      operation_r  <= 4'd0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_fpcsr_r  <= 32'd0;
      rsp_tag_r    <= '0;
      rsp_error_r  <= 1'b0;
    end else if (accept_s) begin
      rsp_tag_r <= core.req_tag;
      if (legal_op_s) begin
        cnt_r        <= 4'(RESULT_LAT - 1);
        acc_enable_r <= 1'b1;
        op_a_r       <= core.req_a;
        op_b_r       <= core.req_b;
        op_c_r       <= core.req_c;
        operation_r  <= core.req_op;
      end else begin
        rsp_valid_r  <= 1'b1;
        rsp_error_r  <= 1'b1;
        rsp_result_r <= 32'd0;
        rsp_fpcsr_r  <= 32'd0;
      end
    end else if (sample_s) begin
      acc_enable_r <= 1'b0;
      rsp_valid_r  <= 1'b1;
      rsp_error_r  <= !acc_valid;
      rsp_result_r <= acc_valid ? acc_result : 32'd0;
      rsp_fpcsr_r  <= acc_valid ? acc_fpcsr : 32'd0;
    end else if (state_r == ISSUE) begin
      cnt_r <= cnt_r - 4'd1;
    end else if (rsp_done_s) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign flag_update_s = sample_s && acc_valid;

  // Sticky flags: a same-cycle clear still keeps the completing operation's flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags_r <= 5'd0;
    end else if (flag_update_s) begin
      fflags_r <= (fflags_clr ? 5'd0 : fflags_r) | acc_fpcsr[4:0];
    end else if (fflags_clr) begin
      fflags_r <= 5'd0;
    end else begin
      fflags_r <= fflags_r;
    end
  end

  assign core.req_ready  = req_ready_s;
  assign core.rsp_valid  = rsp_valid_r;
  assign core.rsp_result = rsp_result_r;
  assign core.rsp_fpcsr  = rsp_fpcsr_r;
  assign core.rsp_tag    = rsp_tag_r;
  assign core.rsp_error  = rsp_error_r;
  assign acc_enable      = acc_enable_r;
  assign acc_operand_a   = op_a_r;
  assign acc_operand_b   = op_b_r;
  assign acc_operand_c   = op_c_r;
  assign acc_operation   = operation_r;
  assign fflags          = fflags_r;
  assign busy            = busy_s;

endmodule

// File: tb/tb_bf16_acc_issuer.sv
// Directed bench for bf16_acc_issuer with a stub accelerator (result = a+b).
module tb_bf16_acc_issuer;

  logic        clk;
  logic        reset;
  logic        acc_enable;
  logic [31:0] acc_operand_a;
  logic [31:0] acc_operand_b;
  logic [31:0] acc_operand_c;
  logic [3:0]  acc_operation;
  logic [31:0] acc_result;
  logic [31:0] acc_fpcsr;
  logic        acc_valid;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        busy;
  logic [31:0] stub_fpcsr;
  logic        stub_valid_en;
  int          tests_run;
  int          tests_failed;

  bf16_acc_issuer_if #(.TAG_W(4)) core_if ();

  bf16_acc_issuer #(.RESULT_LAT(2), .TAG_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .core          (core_if),
    .acc_enable    (acc_enable),
    .acc_operand_a (acc_operand_a),
    .acc_operand_b (acc_operand_b),
    .acc_operand_c (acc_operand_c),
    .acc_operation (acc_operation),
    .acc_result    (acc_result),
    .acc_fpcsr     (acc_fpcsr),
    .acc_valid     (acc_valid),
    .fflags        (fflags),
    .fflags_clr    (fflags_clr),
    .busy          (busy)
  );

  assign acc_result = acc_operand_a + acc_operand_b;
  assign acc_fpcsr  = stub_fpcsr;
  assign acc_valid  = acc_enable & stub_valid_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
    core_if.req_valid = 1'b1;
    core_if.req_op    = op;
    core_if.req_a     = a;
    core_if.req_b     = b;
    core_if.req_c     = 32'h0000_0000;
    core_if.req_tag   = tag;
  endtask

  task automatic pulse_rsp_ready();
    core_if.rsp_ready = 1'b1;
    @(negedge clk);
    core_if.rsp_ready = 1'b0;
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    reset             = 1'b1;
    fflags_clr        = 1'b0;
    stub_fpcsr        = 32'h0000_0001;
    stub_valid_en     = 1'b1;
    core_if.req_valid = 1'b0;
    core_if.req_op    = 4'd0;
    core_if.req_a     = 32'd0;
    core_if.req_b     = 32'd0;
    core_if.req_c     = 32'd0;
    core_if.req_tag   = 4'd0;
    core_if.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 32'(core_if.req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(core_if.rsp_valid), 32'd0);
    check_val("rst_acc_enable", 32'(acc_enable), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rsp_error", 32'(core_if.rsp_error), 32'd0);
    check_val("rst_rsp_tag", 32'(core_if.rsp_tag), 32'd0);
    check_val("rst_fflags", 32'(fflags), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Legal op, RESULT_LAT = 2
    drive_req(4'b0100, 32'h3F80, 32'h4000, 4'd3);
    check_val("t1_req_ready", 32'(core_if.req_ready), 32'd1);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check_val("t1_en_c1", 32'(acc_enable), 32'd1);
    check_val("t1_busy_c1", 32'(busy), 32'd1);
    check_val("t1_ready_c1", 32'(core_if.req_ready), 32'd0);
    check_val("t1_operation", 32'(acc_operation), 32'h4);
    check_val("t1_operand_a", acc_operand_a, 32'h3F80);
    @(negedge clk);
    check_val("t1_en_c2", 32'(acc_enable), 32'd1);
    check_val("t1_rspv_c2", 32'(core_if.rsp_valid), 32'd0);
    @(negedge clk);
    check_val("t1_en_c3", 32'(acc_enable), 32'd0);
    check_val("t1_rspv_c3", 32'(core_if.rsp_valid), 32'd1);
    check_val("t1_result", core_if.rsp_result, 32'h7F80);
    check_val("t1_fpcsr", core_if.rsp_fpcsr, 32'h1);
    check_val("t1_tag", 32'(core_if.rsp_tag), 32'd3);
    check_val("t1_error", 32'(core_if.rsp_error), 32'd0);
    check_val("t1_fflags", 32'(fflags), 32'h01);
    pulse_rsp_ready();
    check_val("t1_rspv_done", 32'(core_if.rsp_valid), 32'd0);
    check_val("t1_idle", 32'(core_if.req_ready), 32'd1);

    // Illegal op goes straight to an error response
    drive_req(4'b1100, 32'h1, 32'h2, 4'd5);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check_val("t2_en", 32'(acc_enable), 32'd0);
    check_val("t2_rspv", 32'(core_if.rsp_valid), 32'd1);
    check_val("t2_error", 32'(core_if.rsp_error), 32'd1);
    check_val("t2_result", core_if.rsp_result, 32'd0);
    check_val("t2_tag", 32'(core_if.rsp_tag), 32'd5);
    check_val("t2_fflags", 32'(fflags), 32'h01);
    pulse_rsp_ready();

    // Accelerator never valid
    stub_valid_en = 1'b0;
    stub_fpcsr    = 32'h0000_0008;
    drive_req(4'b0101, 32'h1, 32'h2, 4'd6);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("t3_rspv", 32'(core_if.rsp_valid), 32'd1);
    check_val("t3_error", 32'(core_if.rsp_error), 32'd1);
    check_val("t3_result", core_if.rsp_result, 32'd0);
    check_val("t3_fpcsr", core_if.rsp_fpcsr, 32'd0);
    check_val("t3_fflags", 32'(fflags), 32'h01);
    pulse_rsp_ready();
    stub_valid_en = 1'b1;
    stub_fpcsr    = 32'h0000_0001;

    // Back-pressure: response held, next request waits
    drive_req(4'b0000, 32'h10, 32'h20, 4'd7);
    @(negedge clk);
    drive_req(4'b0000, 32'h1, 32'h1, 4'd8);
    check_val("t4_ready_c1", 32'(core_if.req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_val("t4_hold_ready", 32'(core_if.req_ready), 32'd0);
      check_val("t4_hold_rspv", 32'(core_if.rsp_valid), 32'd1);
      check_val("t4_hold_tag", 32'(core_if.rsp_tag), 32'd7);
      check_val("t4_hold_result", core_if.rsp_result, 32'h30);
      @(negedge clk);
    end
    pulse_rsp_ready();
    check_val("t4_rspv_done", 32'(core_if.rsp_valid), 32'd0);
    check_val("t4_ready_idle", 32'(core_if.req_ready), 32'd1);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check_val("t4_next_en", 32'(acc_enable), 32'd1);
    check_val("t4_next_ready", 32'(core_if.req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_val("t4_next_rspv", 32'(core_if.rsp_valid), 32'd1);
    check_val("t4_next_tag", 32'(core_if.rsp_tag), 32'd8);
    check_val("t4_next_result", core_if.rsp_result, 32'h2);
    pulse_rsp_ready();

    // Clear coinciding with a flag update keeps the new flags
    stub_fpcsr = 32'h0000_0010;
    drive_req(4'b0001, 32'h0, 32'h0, 4'd2);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check_val("t5_fflags", 32'(fflags), 32'h10);
    check_val("t5_fpcsr", core_if.rsp_fpcsr, 32'h10);
    pulse_rsp_ready();
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check_val("t5_clr_idle", 32'(fflags), 32'h0);

    // Reset during the second ISSUE cycle
    drive_req(4'b0010, 32'h5, 32'h6, 4'd9);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check_val("t6_en_c1", 32'(acc_enable), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("t6_en_rst", 32'(acc_enable), 32'd0);
    check_val("t6_busy_rst", 32'(busy), 32'd0);
    check_val("t6_ready_rst", 32'(core_if.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t6_no_rsp", 32'(core_if.rsp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bf16_acc_issuer.md
# bf16_acc_issuer

Request-side controller for the BF16 accelerator top. It accepts operation requests from the core over a valid/ready handshake, registers and drives the accelerator's `enable`/operand/`operation` inputs for a fixed number of cycles, and samples `result`/`fpcsr`/`valid` at the end of that window. It returns a tagged response over a second valid/ready handshake and keeps sticky exception flags. It sits between the core's offload port and `bf16_accelerator_top`.

## Interface
- `RESULT_LAT`, default 2: number of cycles `acc_enable` is held high before the result is sampled; legal range 1..15.
- `TAG_W`, default 4: width of the request/response tag.

Ports:
- `clk`  in  1  the only clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  issuer can accept a request.
- `req_op`  in  4  accelerator operation code.
- `req_a`, `req_b`, `req_c`  in  32 each  operands.
- `req_tag`  in  TAG_W  request identifier.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_result`  out  32  sampled result.
- `rsp_fpcsr`  out  32  sampled fpcsr.
- `rsp_tag`  out  TAG_W  tag of the request.
- `rsp_error`  out  1  illegal opcode, or accelerator `valid` low at the sample point.
- `acc_enable`  out  1  to the accelerator `enable`.
- `acc_operand_a`, `acc_operand_b`, `acc_operand_c`  out  32 each  to the accelerator operands.
- `acc_operation`  out  4  to the accelerator `operation`.
- `acc_result`, `acc_fpcsr`  in  32 each  from the accelerator.
- `acc_valid`  in  1  from the accelerator.
- `fflags`  out  5  sticky OR of `fpcsr[4:0]` over completed operations.
- `fflags_clr`  in  1  synchronous clear of `fflags`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - When `req_valid` is high, register op, operands and tag.
  - If op ≤ 4'b1010, go to ISSUE and load `cnt` = RESULT_LAT-1.
  - If op > 4'b1010, go directly to RESP with `rsp_error` = 1, result = 0, fpcsr = 0. The accelerator is not driven.
- **ISSUE:**
  - `acc_enable` = 1; `acc_operand_*` and `acc_operation` come from the registers and are stable for the whole window.
  - `cnt` decrements each cycle.
  - On the cycle `cnt` == 0, sample `acc_result` and `acc_fpcsr`, set `rsp_error` = !`acc_valid`, and go to RESP.
  - If `acc_valid` was low at the sample, the captured result and fpcsr are forced to 0.
- **RESP:**
  - `rsp_valid` = 1 and all `rsp_*` outputs are held stable until `rsp_ready` is high; then go to IDLE.
  - `req_ready` = 0 in both ISSUE and RESP, so at most one request is outstanding.
- **Flags:**
  - On an ISSUE→RESP transition without error, `fflags` |= `acc_fpcsr[4:0]`.
  - `fflags_clr` zeroes `fflags`.
  - If clear and update happen in the same cycle, `fflags` = `acc_fpcsr[4:0]`: the new operation's flags survive.
  - Error and illegal-op responses never change `fflags`.
- `acc_operand_*` and `acc_operation` hold their last value outside ISSUE; only `acc_enable` gates the accelerator.

## Timing
- **Reset values:** state IDLE; `req_ready` = 1 (combinational from IDLE); `rsp_valid`, `acc_enable`, `rsp_error`, `busy` = 0; all data registers, `rsp_tag` and `fflags` = 0.
- **Legal-op latency:** request accepted at edge 0; `acc_enable` is high in cycles 1..RESULT_LAT; `rsp_valid` rises in cycle RESULT_LAT+1.
  - Minimum accept-to-accept interval is RESULT_LAT+2 cycles when `rsp_ready` is tied high.
- **Illegal-op latency:** accepted at edge 0, `rsp_valid` in cycle 1.
- All outputs except `req_ready` and `busy` are registered. `busy` is decoded from the state register.
- `rsp_ready` high while `rsp_valid` = 0 has no effect. A response is held indefinitely while `rsp_ready` = 0.
- **Reset in any state:** immediate return to IDLE, `acc_enable` drops asynchronously, and any in-flight response is discarded.

## Test plan
- Stub accelerator returns `acc_result` = a+b and `acc_fpcsr` = 0x1, with `acc_valid` = `acc_enable`. Request op 4'b0100, a = 0x3F80, b = 0x4000, tag = 3, RESULT_LAT = 2 → `acc_enable` high for exactly 2 cycles; `rsp_valid` in cycle 3 with `rsp_result` = 0x7F80, `rsp_tag` = 3, `rsp_error` = 0; `fflags` = 0x01.
- Request op 4'b1100, tag = 5 → `acc_enable` never rises; `rsp_valid` in cycle 1 with `rsp_error` = 1, `rsp_result` = 0, `rsp_tag` = 5; `fflags` unchanged.
- Stub with `acc_valid` tied 0, op 4'b0101 → `rsp_error` = 1, `rsp_result` = 0, `fflags` unchanged.
- `rsp_ready` held 0 for 10 cycles while `req_valid` stays high → `req_ready` = 0 throughout, response stable; after one `rsp_ready` pulse the next request is accepted the following cycle.
- `fflags` = 0x01, then an operation returning fpcsr 0x10 completes in the same cycle that `fflags_clr` = 1 → `fflags` = 0x10.
- Assert `reset` in the second ISSUE cycle → `acc_enable` = 0, `busy` = 0, `req_ready` = 1, and no response is ever issued.
